instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
// - Instruction fetch/prefetch stage directly upstream of the CPU core: reads 16-bit words from
//   program memory, buffers them in a small queue, presents them on COMM/COMME.
// - Emits opcode words and extension words in program order; CPU pops one word per COMM_ACK.
// - Handles jumps (queue flush + redirect) and HALT (issue freeze); program memory has 1-cycle read latency.
// PARAMETERS
// - PC_W      12     word-address width of program memory; PC wraps modulo 2**PC_W
// - DEPTH     4      prefetch queue depth in words (power of 2, >= 2)
// - RESET_PC  'h000  word address fetched first after reset
// PORTS
// - F1        in   1     clock; all state updates on posedge F1
// - RESET     in   1     synchronous, active-high reset
// - PMA       out  PC_W  program memory word address
// - PMRD      out  1     program memory read strobe; data returns on PMD the following cycle
// - PMD       in   16    program memory read data, valid exactly 1 cycle after PMRD
// - COMM      out  16    head-of-queue instruction word to CPU
// - COMME     out  1     COMM valid (queue not empty)
// - COMM_PC   out  PC_W  word address of the COMM word
// - COMM_ACK  in   1     CPU consumes head word this cycle
// - JMP       in   1     redirect request
// - JMP_ADDR  in   PC_W  redirect target word address
// - HALT      in   1     freeze new fetches; queue contents held
// - ERR       out  1     sticky: COMM_ACK received while COMME low; cleared only by RESET
// BEHAVIOUR
// - Reset (RESET high at posedge): PC=RESET_PC, queue empty, in-flight and kill flags 0, state BOOT,
//   ERR=0. Outputs: PMRD=0, PMA=RESET_PC, COMME=0, COMM=16'h0000, COMM_PC=RESET_PC.
// - FSM states (enum): BOOT -> RUN unconditionally after 1 cycle (no issue in BOOT);
//   RUN -> HOLD when HALT=1; HOLD -> RUN when HALT=0. JMP is accepted in all three states.
// - Issue (RUN only): PMRD=1, PMA=PC when count + inflight < DEPTH and JMP=0; on issue PC<=PC+1
//   (mod 2**PC_W, 'hFFF -> 'h000 for PC_W=12); inflight<=1 for the next cycle.
// - Return: cycle after issue, PMD and its address are written to tail unless kill=1 (then dropped).
// - Latency: PMRD in cycle N -> word in queue at end of N+1 -> COMME=1 in cycle N+2.
//   Steady-state throughput 1 word/cycle when CPU acks every cycle.
// - COMM/COMM_PC are combinational from queue head; COMME = (count != 0).
// - Pop on COMM_ACK & COMME; simultaneous push and pop keeps count unchanged (legal when full).
// - COMM_ACK with COMME=0: no pop, ERR<=1.
// - JMP (highest priority): queue flushed (count<=0), PC<=JMP_ADDR, no issue that cycle; if a read is
//   in flight, kill<=1 so its return next cycle is discarded. Same-cycle COMM_ACK is ignored
//   (no pop, no ERR). First word at JMP_ADDR issued next cycle if RUN.
// - HOLD: no new PMRD; an in-flight return still lands; COMM_ACK pops normally.
// - JMP during HOLD: flush and PC redirect take effect; fetch resumes at JMP_ADDR once HALT=0.
// - RESET mid-operation dominates JMP/HALT/ACK; an in-flight return after reset is discarded.
// - Queue full: no issue; count never exceeds DEPTH (guaranteed by count+inflight gating).
// STRUCTURE
// - spr430_pkg: fetch_state_t enum {BOOT, RUN, HOLD}; PM_DATA_W=16 constant.
// - Sub-module fetch_fifo: synchronous FIFO of {PC_W addr, 16 data}, DEPTH entries;
//   ports push/pop/flush/count/head, pointer wrap modulo DEPTH.
// - instr_fetch top: PC register, FSM, inflight/kill flags, issue gating, ERR flag.
// TESTING
// - Reset release, PMD=addr+'h4000 model, ACK tied 1: PMRD at cycle 1 with PMA=0; COMME rises cycle 3,
//   COMM='h4000, then 'h4001,'h4002 on consecutive cycles with COMM_PC 0,1,2.
// - ACK held 0: exactly DEPTH=4 reads issued (PMA 0..3), PMRD then stays 0; COMM stays 'h4000;
//   one ACK -> PMRD re-asserts with PMA=4 next cycle.
// - JMP with JMP_ADDR='h100 while read in flight and queue holding 2 words: COMME=0 next cycle,
//   stale return discarded, first COMM after jump = 'h4100 with COMM_PC='h100.
// - PC wrap: JMP_ADDR='hFFE, ACK=1: COMM_PC sequence 'hFFE,'hFFF,'h000,'h001.
// - HALT=1 for 5 cycles mid-stream: no PMRD during HALT, in-flight word still queued, ACKs drain queue
//   to COMME=0; HALT=0 resumes at next sequential PC with no gap/duplicate.
// - COMM_ACK while empty -> ERR=1 and stays 1; COMM_ACK together with JMP -> ERR unchanged;
//   RESET mid-stream -> ERR=0, COMME=0, first post-reset PMA=RESET_PC.

Source files
------------

// File: rtl/spr430_pkg.sv
// Shared types for the instruction fetch slice.
// Provides the fetch FSM state enum and program-memory data width.
package spr430_pkg;

  localparam int PM_DATA_W = 16;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program memory port plus CPU-side COMM channel.
// master = fetch unit, slave = memory/CPU side.
interface instr_fetch_if
  import spr430_pkg::*;
#(
  parameter int PC_W = 12
) ();

  logic [PC_W-1:0]      PMA;
  logic                 PMRD;
  logic [PM_DATA_W-1:0] PMD;
  logic [PM_DATA_W-1:0] COMM;
  logic                 COMME;
  logic [PC_W-1:0]      COMM_PC;
  logic                 COMM_ACK;
  logic                 JMP;
  logic [PC_W-1:0]      JMP_ADDR;
  logic                 HALT;
  logic                 ERR;

  modport master (
    output PMA, PMRD, COMM, COMME,
    output COMM_PC, ERR,
    input  PMD, COMM_ACK, JMP,
    input  JMP_ADDR, HALT
  );

  modport slave (
    input  PMA, PMRD, COMM, COMME,
    input  COMM_PC, ERR,
    output PMD, COMM_ACK, JMP,
    output JMP_ADDR, HALT
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {addr, word} entries, DEPTH a power of 2.
// Ports: clk_i, rst_i, flush_i, push_i/wdata_i, pop_i, count_o, head_o.
module fetch_fifo #(
  parameter int EW    = 28,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [EW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic [EW-1:0] head_o
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  // Flush shares the reset path: a flushed push is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i)
                     - CW'(pop_i);
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/prefetch stage feeding the CPU COMM channel.
// Ports: F1 clock, RESET sync active-high, bus = instr_fetch_if.master.
module instr_fetch
  import spr430_pkg::*;
#(
  parameter int          PC_W     = 12,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 'h000
) (
  input  logic            F1,
  input  logic            RESET,
  instr_fetch_if.master   bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PC_W + PM_DATA_W;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] rpc_q;
  logic            infl_q;
  logic            kill_q;
  logic            err_q;

  logic            issue;
  logic            push;
  logic            pop;
  logic            comme;
  logic [CW:0]     occ;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;

  assign comme = (count != '0);
  assign occ   = {1'b0, count}
               + {{CW{1'b0}}, infl_q};
  // A jump flushes the queue, so any
  // same-cycle return and ack are void.
  assign push  = infl_q & ~kill_q & ~bus.JMP;
  assign pop   = bus.COMM_ACK & comme
               & ~bus.JMP;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN:  if (bus.HALT) state_d = HOLD;
      HOLD: if (!bus.HALT) state_d = RUN;
      default: state_d = BOOT;
    endcase
    // Reserve a slot for the in-flight read
    // so the queue can never overflow.
    if (state_q == RUN && !bus.HALT &&
        !bus.JMP &&
        occ < (CW+1)'(DEPTH))
      issue = 1'b1;
    if (bus.JMP)
      pc_d = bus.JMP_ADDR;
    else if (issue)
      pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge F1) begin
    if (RESET) begin
      state_q <= BOOT;
      pc_q    <= PC_W'(RESET_PC);
      rpc_q   <= PC_W'(RESET_PC);
      infl_q  <= 1'b0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= issue;
      kill_q  <= bus.JMP & infl_q;
      if (issue) rpc_q <= pc_q;
      if (bus.COMM_ACK && !comme &&
          !bus.JMP)
        err_q <= 1'b1;
    end
  end

  fetch_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (F1),
    .rst_i   (RESET),
    .flush_i (bus.JMP),
    .push_i  (push),
    .wdata_i ({rpc_q, bus.PMD}),
    .pop_i   (pop),
    .count_o (count),
    .head_o  (head)
  );

  assign bus.PMRD    = issue;
  assign bus.PMA     = pc_q;
  assign bus.COMME   = comme;
  assign bus.COMM    = comme
                     ? head[PM_DATA_W-1:0]
                     : '0;
  assign bus.COMM_PC = comme
                     ? head[EW-1:PM_DATA_W]
                     : pc_q;
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
// Memory model returns 'h4000 + address one cycle after PMRD.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ack = 1'b0;
  logic        jmp = 1'b0;
  logic        halt = 1'b0;
  logic [11:0] jaddr = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  instr_fetch_if #(.PC_W(12)) bus ();

  assign bus.COMM_ACK = ack;
  assign bus.JMP      = jmp;
  assign bus.JMP_ADDR = jaddr;
  assign bus.HALT     = halt;

  always_ff @(posedge clk)
    bus.PMD <= bus.PMRD
             ? 16'h4000 + 16'(bus.PMA)
             : 16'hDEAD;

  instr_fetch #(
    .PC_W     (12),
    .DEPTH    (4),
    .RESET_PC ('h000)
  ) dut (
    .F1    (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Leaves the caller at the negedge of the BOOT cycle.
  task automatic do_reset;
    @(negedge clk);
    rst = 1; ack = 0; jmp = 0;
    halt = 0; jaddr = '0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1; ack = 0; jmp = 0; halt = 0;
    @(negedge clk);
    #1;
    total++;
    if (bus.PMRD !== 1'b0) begin
      bad++;
      $display("FAIL rst_pmrd got %b want 0", bus.PMRD);
    end
    total++;
    if (bus.PMA !== 12'h000) begin
      bad++;
      $display("FAIL rst_pma got %h want 000", bus.PMA);
    end
    total++;
    if (bus.COMME !== 1'b0) begin
      bad++;
      $display("FAIL rst_comme got %b want 0", bus.COMME);
    end
    total++;
    if (bus.COMM !== 16'h0000) begin
      bad++;
      $display("FAIL rst_comm got %h want 0000", bus.COMM);
    end
    total++;
    if (bus.COMM_PC !== 12'h000) begin
      bad++;
      $display("FAIL rst_commpc got %h want 000", bus.COMM_PC);
    end
    total++;
    if (bus.ERR !== 1'b0) begin
      bad++;
      $display("FAIL rst_err got %b want 0", bus.ERR);
    end
    rst = 0;
  endtask

  task automatic test_stream;
    do_reset();
    ack = 1;
    #1;
    total++;
    if (bus.PMRD !== 1'b0) begin
      bad++;
      $display("FAIL boot_pmrd got %b want 0", bus.PMRD);
    end
    @(negedge clk); #1;
    total++;
    if (bus.PMRD !== 1'b1 || bus.PMA !== 12'h000) begin
      bad++;
      $display("FAIL first_issue got %b/%h want 1/000", bus.PMRD, bus.PMA);
    end
    @(negedge clk); #1;
    total++;
    if (bus.COMME !== 1'b0) begin
      bad++;
      $display("FAIL lat_comme got %b want 0", bus.COMME);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (bus.COMME !== 1'b1 ||
          bus.COMM !== 16'h4000 + 16'(i) ||
          bus.COMM_PC !== 12'(i)) begin
        bad++;
        $display("FAIL stream_%0d got %b/%h/%h want 1/%h/%h", i, bus.COMME, bus.COMM, bus.COMM_PC, 16'h4000 + 16'(i), 12'(i));
      end
    end
    ack = 0;
  endtask

  task automatic test_full;
    int nrd;
    nrd = 0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      if (bus.PMRD) begin
        total++;
        if (bus.PMA !== 12'(nrd)) begin
          bad++;
          $display("FAIL full_pma got %h want %h", bus.PMA, 12'(nrd));
        end
        nrd++;
      end
    end
    total++;
    if (nrd !== 4) begin
      bad++;
      $display("FAIL full_reads got %0d want 4", nrd);
    end
    total++;
    if (bus.COMME !== 1'b1 || bus.COMM !== 16'h4000) begin
      bad++;
      $display("FAIL full_head got %b/%h want 1/4000", bus.COMME, bus.COMM);
    end
    ack = 1;
    @(negedge clk);
    ack = 0;
    #1;
    total++;
    if (bus.PMRD !== 1'b1 || bus.PMA !== 12'h004 ||
        bus.COMM !== 16'h4001) begin
      bad++;
      $display("FAIL full_resume got %b/%h/%h want 1/004/4001", bus.PMRD, bus.PMA, bus.COMM);
    end
  endtask

  task automatic test_jump;
    do_reset();
    repeat (3) @(negedge clk);
    @(negedge clk); #1;
    total++;
    if (bus.COMME !== 1'b1 || bus.COMM !== 16'h4000) begin
      bad++;
      $display("FAIL jmp_pre got %b/%h want 1/4000", bus.COMME, bus.COMM);
    end
    jmp = 1; jaddr = 12'h100;
    #1;
    total++;
    if (bus.PMRD !== 1'b0) begin
      bad++;
      $display("FAIL jmp_noissue got %b want 0", bus.PMRD);
    end
    @(negedge clk);
    jmp = 0;
    #1;
    total++;
    if (bus.COMME !== 1'b0 || bus.PMRD !== 1'b1 ||
        bus.PMA !== 12'h100) begin
      bad++;
      $display("FAIL jmp_flush got %b/%b/%h want 0/1/100", bus.COMME, bus.PMRD, bus.PMA);
    end
    @(negedge clk); #1;
    total++;
    if (bus.COMME !== 1'b0) begin
      bad++;
      $display("FAIL jmp_stale got %b/%h want 0", bus.COMME, bus.COMM);
    end
    @(negedge clk); #1;
    total++;
    if (bus.COMM !== 16'h4100 || bus.COMM_PC !== 12'h100) begin
      bad++;
      $display("FAIL jmp_first got %h/%h want 4100/100", bus.COMM, bus.COMM_PC);
    end
    ack = 1;
    @(negedge clk); #1;
    total++;
    if (bus.COMM !== 16'h4101 || bus.COMM_PC !== 12'h101) begin
      bad++;
      $display("FAIL jmp_second got %h/%h want 4101/101", bus.COMM, bus.COMM_PC);
    end
    ack = 0;
  endtask

  task automatic test_wrap;
    logic [11:0] exp_pc [4];
    exp_pc = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    do_reset();
    jmp = 1; jaddr = 12'hFFE;
    @(negedge clk);
    jmp = 0;
    #1;
    total++;
    if (bus.PMRD !== 1'b1 || bus.PMA !== 12'hFFE) begin
      bad++;
      $display("FAIL wrap_issue got %b/%h want 1/ffe", bus.PMRD, bus.PMA);
    end
    @(negedge clk);
    @(negedge clk); #1;
    total++;
    if (bus.PMA !== 12'h000) begin
      bad++;
      $display("FAIL wrap_pma got %h want 000", bus.PMA);
    end
    ack = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      total++;
      if (bus.COMM_PC !== exp_pc[i] ||
          bus.COMM !== 16'h4000 + 16'(exp_pc[i])) begin
        bad++;
        $display("FAIL wrap_%0d got %h/%h want %h", i, bus.COMM_PC, bus.COMM, exp_pc[i]);
      end
    end
    ack = 0;
  endtask

  task automatic test_halt;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ack = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (bus.COMM !== 16'h4000 + 16'(i)) begin
        bad++;
        $display("FAIL halt_pre_%0d got %h want %h", i, bus.COMM, 16'h4000 + 16'(i));
      end
    end
    @(negedge clk);
    halt = 1;
    #1;
    total++;
    if (bus.PMRD !== 1'b0 || bus.COMM !== 16'h4003) begin
      bad++;
      $display("FAIL halt_c6 got %b/%h want 0/4003", bus.PMRD, bus.COMM);
    end
    @(negedge clk); #1;
    total++;
    if (bus.PMRD !== 1'b0 || bus.COMME !== 1'b1 ||
        bus.COMM !== 16'h4004) begin
      bad++;
      $display("FAIL halt_land got %b/%b/%h want 0/1/4004", bus.PMRD, bus.COMME, bus.COMM);
    end
    @(negedge clk);
    ack = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (bus.PMRD !== 1'b0 || bus.COMME !== 1'b0) begin
        bad++;
        $display("FAIL halt_drain_%0d got %b/%b want 0/0", i, bus.PMRD, bus.COMME);
      end
    end
    @(negedge clk);
    halt = 0;
    #1;
    total++;
    if (bus.PMRD !== 1'b0) begin
      bad++;
      $display("FAIL halt_exit got %b want 0", bus.PMRD);
    end
    @(negedge clk); #1;
    total++;
    if (bus.PMRD !== 1'b1 || bus.PMA !== 12'h005) begin
      bad++;
      $display("FAIL halt_resume got %b/%h want 1/005", bus.PMRD, bus.PMA);
    end
    @(negedge clk);
    @(negedge clk); #1;
    total++;
    if (bus.COMM !== 16'h4005 || bus.COMM_PC !== 12'h005) begin
      bad++;
      $display("FAIL halt_next got %h/%h want 4005/005", bus.COMM, bus.COMM_PC);
    end
    ack = 1;
    @(negedge clk); #1;
    total++;
    if (bus.COMM !== 16'h4006) begin
      bad++;
      $display("FAIL halt_seq got %h want 4006", bus.COMM);
    end
    ack = 0;
  endtask

  task automatic test_err;
    do_reset();
    #1;
    total++;
    if (bus.ERR !== 1'b0) begin
      bad++;
      $display("FAIL err_init got %b want 0", bus.ERR);
    end
    ack = 1;
    @(negedge clk);
    ack = 0;
    #1;
    total++;
    if (bus.ERR !== 1'b1) begin
      bad++;
      $display("FAIL err_set got %b want 1", bus.ERR);
    end
    @(negedge clk);
    @(negedge clk); #1;
    total++;
    if (bus.ERR !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got %b want 1", bus.ERR);
    end
    @(negedge clk); #1;
    total++;
    if (bus.PMRD !== 1'b1 || bus.PMA !== 12'h003) begin
      bad++;
      $display("FAIL err_inflight got %b/%h want 1/003", bus.PMRD, bus.PMA);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    total++;
    if (bus.ERR !== 1'b0 || bus.COMME !== 1'b0 ||
        bus.PMA !== 12'h000) begin
      bad++;
      $display("FAIL midrst got %b/%b/%h want 0/0/000", bus.ERR, bus.COMME, bus.PMA);
    end
    @(negedge clk); #1;
    total++;
    if (bus.PMRD !== 1'b1 || bus.PMA !== 12'h000 ||
        bus.COMME !== 1'b0) begin
      bad++;
      $display("FAIL midrst_issue got %b/%h/%b want 1/000/0", bus.PMRD, bus.PMA, bus.COMME);
    end
    @(negedge clk); #1;
    total++;
    if (bus.COMME !== 1'b0) begin
      bad++;
      $display("FAIL midrst_drop got %b want 0", bus.COMME);
    end
    jmp = 1; ack = 1; jaddr = 12'h020;
    @(negedge clk);
    jmp = 0; ack = 0;
    #1;
    total++;
    if (bus.ERR !== 1'b0) begin
      bad++;
      $display("FAIL err_jmpack got %b want 0", bus.ERR);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_jump();
    test_wrap();
    test_halt();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
